branch_ctrl: RTL and testbench
==============================

# branch_ctrl

ID-stage branch controller that sequences the operand comparator for conditional branches in the pipelined MIPS core. It waits until both branch operands are valid from the forwarding network, evaluates the branch condition, computes the target, and hands a redirect to the PC unit through a valid/ready handshake. While a branch cannot be resolved, it stalls the ID stage. Delay-slot semantics are preserved: the branch never flushes IF.

## Interface
- `IMM_W`, 16, width of the branch offset field (word offset, sign-extended)
- `clk` input 1 — core clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `br_valid` input 1 — ID holds a conditional branch this cycle
- `br_op` input 3 — 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez; 6–7 reserved
- `rs_data`, `rt_data` input 32 — forwarded operands
- `rs_ready`, `rt_ready` input 1 — operand is final (no pending load or ALU result)
- `pc_plus4` input 32 — address of the delay slot
- `imm` input `IMM_W` — branch offset
- `flush` input 1 — exception/eret kill; discards any pending branch
- `stall_id` output 1 — freeze PC/IF/ID this cycle
- `redirect_valid` output 1 — registered; target is pending
- `redirect_target` output 32 — registered branch target
- `redirect_ready` input 1 — PC unit consumes the redirect this cycle
- `br_accept` output 1 — the branch in ID is resolved this cycle (debug/trace)

## Operation
- FSM states:
  - IDLE — no branch pending.
  - WAIT — branch in ID, at least one operand not ready.
  - HOLD — taken redirect issued but not yet consumed.
- Operand need:
  - beq/bne need rs and rt.
  - blez/bgtz/bltz/bgez need rs only; `rt_ready` is ignored.
- IDLE/WAIT accept condition: `br_valid` and all needed operands ready and not `flush`. On accept:
  - `br_accept`=1.
  - Evaluate the condition.
  - If taken: load `redirect_target`, set `redirect_valid`, go to HOLD.
  - If not taken: go to IDLE.
- IDLE/WAIT with `br_valid` and an operand not ready: `stall_id`=1, go to WAIT.
- WAIT with `br_valid` dropping: return to IDLE with no side effects.
- Conditions:
  - eq: `rs==rt`
  - ne: `rs!=rt`
  - lez: `rs[31] | rs==0`
  - gtz: `!rs[31] & rs!=0`
  - ltz: `rs[31]`
  - gez: `!rs[31]`
- Reserved `br_op` is treated as not taken and accepted normally.
- Target: `pc_plus4 + (sext(imm) << 2)`, modulo 2^32 (wrap-around is silent).
- HOLD:
  - `redirect_valid`=1, and `redirect_target` is stable until `redirect_valid & redirect_ready`.
  - On the handshake, clear and go to IDLE.
  - `stall_id`=1 whenever `br_valid` is asserted in HOLD: a second branch is not evaluated until the first redirect is consumed.
- `flush` has priority in every state:
  - Next state is IDLE; `redirect_valid` is cleared next edge.
  - `br_accept`=0 and `stall_id`=0 that cycle.

## Timing
- Reset (async, `rst_n` low): state IDLE, `redirect_valid`=0, `redirect_target`=0. The combinational outputs `stall_id` and `br_accept` also evaluate to 0 with no branch present.
- `stall_id` and `br_accept` are combinational from the current inputs and state. They are never both 1.
- Accept in cycle N → `redirect_valid`=1 from cycle N+1. The delay-slot instruction enters ID in N+1.
- The redirect can be consumed in N+1 at the earliest, so the minimum HOLD residency is 1 cycle.
- `redirect_ready` in the same cycle as `flush`: flush wins and the redirect is dropped.
- Reset asserted mid-HOLD clears the redirect immediately (asynchronously).

## Configuration
- Macro: `BRANCH_CTRL_STATS_EN`.
- When defined, the block adds three output ports, each a 32-bit counter that saturates at 0xFFFFFFFF, is reset to 0, and is cleared by nothing else:
  - `stat_branches` — counts accepted branches.
  - `stat_taken` — counts accepted taken branches.
  - `stat_stall_cycles` — counts cycles with `stall_id`=1.
- When undefined, the ports and counters are absent and the functional behaviour is identical.

## Test plan
- Reset then beq, rs=rt=0x1234, both ready, pc_plus4=0x3004, imm=0x0004:
  - `br_accept` in cycle N.
  - `redirect_valid`=1 with target 0x3014 in N+1.
  - Ready held 1 → cleared in N+2.
- bne, rs=rt, rt_ready low for 3 cycles:
  - `stall_id`=1 for 3 cycles.
  - Accept on the 4th cycle.
  - No redirect.
  - Stats: stall_cycles=3, branches=1, taken=0.
- bltz, rs=0x80000000, rt_ready=0:
  - Accepted immediately (rt ignored), taken.
  - imm=0xFFFF, pc_plus4=0x0 → target 0xFFFFFFFC (wrap).
- Taken branch with `redirect_ready`=0 for 2 cycles while a second branch is in ID:
  - `stall_id`=1 and `redirect_target` is stable through both cycles.
  - The second branch is accepted the cycle after the handshake.
- `flush` during HOLD with `redirect_ready`=1 in the same cycle:
  - `redirect_valid`=0 next cycle and state is IDLE.
  - Stats: taken count unchanged from the accept.
- Assert `rst_n` low mid-WAIT, between clock edges:
  - Outputs go to reset values immediately.
  - After release, the same branch resolves normally.

Source files
------------

// File: rtl/branch_ctrl.sv
// ID-stage branch resolver: accept is combinational, redirect registered one cycle later; holds until redirect_ready.
// Stalls ID while operands are pending or a redirect is held; BRANCH_CTRL_STATS_EN adds saturating statistic counters.
module branch_ctrl #(
   parameter int IMM_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   input  logic [2:0]       br_op,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic [31:0]      pc_plus4,
   input  logic [IMM_W-1:0] imm,
   input  logic             flush,
   output logic             stall_id,
   output logic             redirect_valid,
   output logic [31:0]      redirect_target,
   input  logic             redirect_ready,
   output logic             br_accept
`ifdef BRANCH_CTRL_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_taken,
   output logic [31:0]      stat_stall_cycles
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam int         EXT_W = 30 - IMM_W;

   logic [1:0]  state_q, state_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_target_q, redirect_target_d;

   logic        need_rt, ops_rdy, in_hold, taken, rs_zero, rs_neg;
   logic [31:0] offset, target;

   assign need_rt = (br_op == 3'd0) || (br_op == 3'd1);
   assign ops_rdy = rs_ready && (rt_ready || !need_rt);
   assign in_hold = (state_q == HOLD);

   // A held redirect blocks evaluation of the next branch, so the delay slot is never lost.
   assign br_accept = br_valid && ops_rdy && !flush && !in_hold;
   assign stall_id  = br_valid && !flush && (in_hold || !ops_rdy);

   assign rs_zero = (rs_data == 32'd0);
   assign rs_neg  = rs_data[31];

   always_comb begin
      taken = 1'b0;
      case (br_op)
         3'd0:    taken = (rs_data == rt_data);
         3'd1:    taken = (rs_data != rt_data);
         3'd2:    taken = rs_neg || rs_zero;
         3'd3:    taken = !rs_neg && !rs_zero;
         3'd4:    taken = rs_neg;
         3'd5:    taken = !rs_neg;
         default: taken = 1'b0;
      endcase
   end

   assign offset = {{EXT_W{imm[IMM_W-1]}}, imm, 2'b00};
   assign target = pc_plus4 + offset;

   always_comb begin
      state_d           = state_q;
      redirect_valid_d  = redirect_valid_q;
      redirect_target_d = redirect_target_q;
      if (flush) begin
         state_d          = IDLE;
         redirect_valid_d = 1'b0;
      end else if (in_hold) begin
         if (redirect_ready) begin
            state_d          = IDLE;
            redirect_valid_d = 1'b0;
         end
      end else if (br_accept) begin
         if (taken) begin
            state_d           = HOLD;
            redirect_valid_d  = 1'b1;
            redirect_target_d = target;
         end else begin
            state_d = IDLE;
         end
      end else if (br_valid) begin
         state_d = WAIT;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         redirect_valid_q  <= 1'b0;
         redirect_target_q <= 32'd0;
      end else begin
         state_q           <= state_d;
         redirect_valid_q  <= redirect_valid_d;
         redirect_target_q <= redirect_target_d;
      end
   end

   assign redirect_valid  = redirect_valid_q;
   assign redirect_target = redirect_target_q;

`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0] stat_branches_q, stat_taken_q, stat_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_q <= 32'd0;
         stat_taken_q    <= 32'd0;
         stat_stall_q    <= 32'd0;
      end else begin
         if (br_accept && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_q <= stat_branches_q + 32'd1;
         if (br_accept && taken && (stat_taken_q != 32'hFFFF_FFFF))
            stat_taken_q <= stat_taken_q + 32'd1;
         if (stall_id && (stat_stall_q != 32'hFFFF_FFFF))
            stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_branches     = stat_branches_q;
   assign stat_taken        = stat_taken_q;
   assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboarded bench for branch_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid;
   logic [2:0]  br_op;
   logic [31:0] rs_data, rt_data, pc_plus4;
   logic        rs_ready, rt_ready, flush, redirect_ready;
   logic [15:0] imm;
   logic        stall_id, redirect_valid, br_accept;
   logic [31:0] redirect_target;
`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0] stat_branches, stat_taken, stat_stall_cycles;
`endif

   always #5 clk = ~clk;

   branch_ctrl #(.IMM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
      .rs_data(rs_data), .rt_data(rt_data), .rs_ready(rs_ready), .rt_ready(rt_ready),
      .pc_plus4(pc_plus4), .imm(imm), .flush(flush), .stall_id(stall_id),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .redirect_ready(redirect_ready), .br_accept(br_accept)
`ifdef BRANCH_CTRL_STATS_EN
      , .stat_branches(stat_branches), .stat_taken(stat_taken),
      .stat_stall_cycles(stat_stall_cycles)
`endif
   );

   typedef struct packed {logic acc; logic stall; logic rv;} cyc_t;
   cyc_t        cyc_q[$];
   logic [31:0] rd_q[$];
   cyc_t        mon_e;
   int          vecs = 0;
   int          errs = 0;
   bit          mon_en = 0;

   // Reference model: at most one outstanding redirect, plus event counters.
   bit          m_pend = 0;
   logic [31:0] m_br = 0, m_tk = 0, m_st = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic bit taken_of(logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
      case (op)
         3'd0:    return rs == rt;
         3'd1:    return rs != rt;
         3'd2:    return $signed(rs) <= 0;
         3'd3:    return $signed(rs) > 0;
         3'd4:    return $signed(rs) < 0;
         3'd5:    return $signed(rs) >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step(input bit bv, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit rsr, input bit rtr, input logic [31:0] pc, input logic [15:0] im,
                       input bit fl, input bit rr);
      cyc_t e;
      int   off;
      @(posedge clk);
      #1;
      br_valid = bv; br_op = op; rs_data = rs; rt_data = rt; rs_ready = rsr; rt_ready = rtr;
      pc_plus4 = pc; imm = im; flush = fl; redirect_ready = rr;
      e.rv = m_pend; e.acc = 1'b0; e.stall = 1'b0;
      if (fl) begin
         m_pend = 1'b0;
      end else if (m_pend) begin
         e.stall = bv;
         if (rr) m_pend = 1'b0;
      end else if (bv) begin
         if (rsr && (rtr || op > 3'd1)) begin
            e.acc = 1'b1;
            m_br++;
            if (taken_of(op, rs, rt)) begin
               m_tk++;
               m_pend = 1'b1;
               off = int'($signed(im));
               rd_q.push_back(pc + 32'(off * 4));
            end
         end else begin
            e.stall = 1'b1;
         end
      end
      if (e.stall) m_st++;
      cyc_q.push_back(e);
   endtask

   task automatic idle(input bit rr);
      step(0, 3'd0, 32'd0, 32'd0, 0, 0, 32'd0, 16'd0, 0, rr);
   endtask

   task automatic mid_reset(input bit exp_stall);
      @(negedge clk);
      #2;
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_tgt", redirect_target, 32'd0);
      chk("rst_acc", {31'd0, br_accept}, 32'd0);
      chk("rst_stall", {31'd0, stall_id}, {31'd0, exp_stall});
      @(negedge clk);
      rst_n = 1'b1;
      cyc_q.delete();
      rd_q.delete();
      m_pend = 0; m_br = 0; m_tk = 0; m_st = 0;
      mon_en = 1;
   endtask

   always @(negedge clk) begin
      if (mon_en && cyc_q.size() > 0) begin
         mon_e = cyc_q.pop_front();
         chk("br_accept", {31'd0, br_accept}, {31'd0, mon_e.acc});
         chk("stall_id", {31'd0, stall_id}, {31'd0, mon_e.stall});
         chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mon_e.rv});
         if (redirect_valid) begin
            if (rd_q.size() == 0) begin
               vecs++; errs++;
               $display("FAIL redirect_unexpected: target %h with no redirect expected", redirect_target);
            end else begin
               chk("redirect_target", redirect_target, rd_q[0]);
               if (redirect_ready || flush) void'(rd_q.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] s_br, s_st, r_rs, r_rt;
   logic [2:0]  r_op;
   bit          r_rsr, r_rtr;

   initial begin
      rst_n = 1'b0; br_valid = 0; br_op = 0; rs_data = 0; rt_data = 0; rs_ready = 0; rt_ready = 0;
      pc_plus4 = 0; imm = 0; flush = 0; redirect_ready = 0;
      #1;
      chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
      chk("reset_tgt", redirect_target, 32'd0);
      chk("reset_stall", {31'd0, stall_id}, 32'd0);
      chk("reset_acc", {31'd0, br_accept}, 32'd0);
      #12;
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1;

      // beq taken, target 0x3014, consumed immediately
      step(1, 3'd0, 32'h1234, 32'h1234, 1, 1, 32'h3004, 16'h0004, 0, 1);
      #1 chk("t1_acc", {31'd0, br_accept}, 32'd1);
      idle(1);
      #1 chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
      chk("t1_tgt", redirect_target, 32'h3014);
      idle(1);
      #1 chk("t1_clr", {31'd0, redirect_valid}, 32'd0);

      // bne, rt pending 3 cycles
`ifdef BRANCH_CTRL_STATS_EN
      s_br = stat_branches; s_st = stat_stall_cycles;
`endif
      repeat (3) begin
         step(1, 3'd1, 32'h55, 32'h55, 1, 0, 32'h400, 16'h8, 0, 1);
         #1 chk("t2_stall", {31'd0, stall_id}, 32'd1);
      end
      step(1, 3'd1, 32'h55, 32'h55, 1, 1, 32'h400, 16'h8, 0, 1);
      #1 chk("t2_acc", {31'd0, br_accept}, 32'd1);
      idle(1);
      #1 chk("t2_norv", {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_CTRL_STATS_EN
      chk("t2_stat_stall", stat_stall_cycles - s_st, 32'd3);
      chk("t2_stat_br", stat_branches - s_br, 32'd1);
`endif

      // bltz ignores rt_ready; target wraps
      step(1, 3'd4, 32'h8000_0000, 32'd0, 1, 0, 32'h0, 16'hFFFF, 0, 1);
      #1 chk("t3_acc", {31'd0, br_accept}, 32'd1);
      idle(1);
      #1 chk("t3_tgt", redirect_target, 32'hFFFF_FFFC);
      idle(1);

      // held redirect with a second branch waiting
      step(1, 3'd0, 32'd7, 32'd7, 1, 1, 32'h100, 16'h0010, 0, 0);
      repeat (2) begin
         step(1, 3'd1, 32'd1, 32'd2, 1, 1, 32'h200, 16'h0003, 0, 0);
         #1 chk("t4_stall", {31'd0, stall_id}, 32'd1);
         chk("t4_tgt", redirect_target, 32'h140);
      end
      step(1, 3'd1, 32'd1, 32'd2, 1, 1, 32'h200, 16'h0003, 0, 1);
      step(1, 3'd1, 32'd1, 32'd2, 1, 1, 32'h200, 16'h0003, 0, 0);
      #1 chk("t4_acc2", {31'd0, br_accept}, 32'd1);
      idle(1);
      idle(1);

      // flush beats a simultaneous handshake
      step(1, 3'd3, 32'd5, 32'd0, 1, 0, 32'h800, 16'h0001, 0, 0);
      step(0, 3'd0, 32'd0, 32'd0, 0, 0, 32'd0, 16'd0, 1, 1);
      idle(0);
      #1 chk("t5_rv", {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_CTRL_STATS_EN
      chk("t5_stat_taken", stat_taken, m_tk);
`endif

      // async reset mid-WAIT, then the same branch resolves
      repeat (2) step(1, 3'd0, 32'd9, 32'd9, 1, 0, 32'h1000, 16'h0002, 0, 1);
      mid_reset(1'b1);
      step(1, 3'd0, 32'd9, 32'd9, 1, 1, 32'h1000, 16'h0002, 0, 1);
      #1 chk("t6_acc", {31'd0, br_accept}, 32'd1);
      idle(1);
      #1 chk("t6_tgt", redirect_target, 32'h1008);
      idle(1);

      // async reset mid-HOLD drops the redirect at once
      step(1, 3'd5, 32'd3, 32'd0, 1, 0, 32'h2000, 16'h0004, 0, 0);
      idle(0);
      mid_reset(1'b0);

      repeat (1500) begin
         r_op  = 3'($urandom_range(0, 7));
         r_rs  = pick();
         r_rt  = ($urandom_range(0, 1) != 0) ? r_rs : pick();
         r_rsr = ($urandom_range(0, 3) != 0);
         r_rtr = ($urandom_range(0, 3) != 0);
         if (r_op > 3'd5) begin
            r_rsr = 1; r_rtr = 1;
         end
         step($urandom_range(0, 9) < 7, r_op, r_rs, r_rt, r_rsr, r_rtr, $urandom, 16'($urandom),
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) != 0);
      end
      repeat (3) idle(1);
      @(negedge clk);
      #1;
`ifdef BRANCH_CTRL_STATS_EN
      chk("stat_branches", stat_branches, m_br);
      chk("stat_taken", stat_taken, m_tk);
      chk("stat_stall_cycles", stat_stall_cycles, m_st);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
